// File: rtl/mac_operand_feeder.sv
// rtl/mac_operand_feeder.sv - FIFO-buffered operand pair feeder issuing fixed-length frames to a MAC
module mac_operand_feeder #(
    parameter int DEPTH     = 8,
    parameter int FRAME_LEN = 4
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     in_valid,
    input  logic [3:0]               in_a,
    input  logic [3:0]               in_b,
    output logic                     in_ready,
    input  logic                     start,
    output logic [3:0]               Data_a,
    output logic [3:0]               Data_b,
    output logic                     out_valid,
    output logic                     frame_done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [7:0]    LAST_CNT = 8'(FRAME_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [7:0]      count;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [7:0]      mem [DEPTH];
    logic            push;
    logic            pop;

    // in_ready depends on the registered level only, so a full FIFO refuses
    // a push even when a pop frees a slot on the same edge.
    assign in_ready = (level != FULL_LVL);
    assign push     = in_valid && in_ready;
    assign busy     = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (level != '0) begin
                    pop = 1'b1;
                    if (count + 8'd1 == LAST_CNT) begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= S_IDLE;
            count <= 8'd0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && start) begin
                count <= 8'd0;
            end else if (pop) begin
                count <= count + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_a, in_b};
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Non-issuing cycles drive zero operands so the MAC accumulates 0*0.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            Data_a     <= 4'd0;
            Data_b     <= 4'd0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= (state == S_DONE);
            if (pop) begin
                Data_a    <= mem[rd_ptr][7:4];
                Data_b    <= mem[rd_ptr][3:0];
                out_valid <= 1'b1;
            end else begin
                Data_a    <= 4'd0;
                Data_b    <= 4'd0;
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mac_operand_feeder.sv
// tb/tb_mac_operand_feeder.sv - self-checking bench for mac_operand_feeder
module tb_mac_operand_feeder;

    localparam int DEPTH     = 8;
    localparam int FRAME_LEN = 4;

    logic       clk;
    logic       rst_b;
    logic       in_valid;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       in_ready;
    logic       start;
    logic [3:0] Data_a;
    logic [3:0] Data_b;
    logic       out_valid;
    logic       frame_done;
    logic       busy;
    logic [3:0] level;

    mac_operand_feeder #(.DEPTH(DEPTH), .FRAME_LEN(FRAME_LEN)) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .in_valid   (in_valid),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_ready   (in_ready),
        .start      (start),
        .Data_a     (Data_a),
        .Data_b     (Data_b),
        .out_valid  (out_valid),
        .frame_done (frame_done),
        .busy       (busy),
        .level      (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pairs plus frame bookkeeping.
    logic [7:0] mq[$];
    bit         m_active  = 0;
    bit         m_pending = 0;
    int         m_issued  = 0;
    int         e_a = 0, e_b = 0, e_v = 0, e_fd = 0;
    int         acc = 0, vcount = 0, fd_total = 0, max_level = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_b) begin
                mq.delete();
                m_active  = 0;
                m_pending = 0;
                m_issued  = 0;
                e_a = 0; e_b = 0; e_v = 0; e_fd = 0;
            end
            check("Data_a", Data_a, e_a);
            check("Data_b", Data_b, e_b);
            check("out_valid", out_valid, e_v);
            check("frame_done", frame_done, e_fd);
            check("busy", busy, int'(m_active || m_pending));
            check("level", level, mq.size());
            check("in_ready", in_ready, int'(mq.size() != DEPTH));
            acc      += int'(Data_a) * int'(Data_b);
            vcount   += int'(out_valid);
            fd_total += int'(frame_done);
            if (int'(level) > max_level) max_level = int'(level);
            if (rst_b) begin
                bit do_push;
                do_push = in_valid && (mq.size() < DEPTH);
                e_a = 0; e_b = 0; e_v = 0; e_fd = 0;
                if (m_active) begin
                    if (mq.size() > 0) begin
                        e_a = int'(mq[0][7:4]);
                        e_b = int'(mq[0][3:0]);
                        e_v = 1;
                        void'(mq.pop_front());
                        m_issued++;
                        if (m_issued == FRAME_LEN) begin
                            m_active  = 0;
                            m_pending = 1;
                        end
                    end
                end else if (m_pending) begin
                    e_fd      = 1;
                    m_pending = 0;
                end else if (start) begin
                    m_active = 1;
                    m_issued = 0;
                end
                if (do_push) mq.push_back({in_a, in_b});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] a, input logic [3:0] b);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        step();
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_fd(input string name);
        int seen;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (frame_done) begin
                seen = 1;
                break;
            end
        end
        check(name, seen, 1);
        step();
    endtask

    int a0, v0, f0;

    initial begin
        rst_b    = 1'b1;
        in_valid = 1'b0;
        in_a     = 4'd0;
        in_b     = 4'd0;
        start    = 1'b0;
        #2 rst_b = 1'b0;
        @(negedge clk);
        check("rst_data_a", Data_a, 0);
        check("rst_level", level, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        step();
        step();
        rst_b = 1'b1;
        step();

        // Basic frame
        a0 = acc; v0 = vcount; f0 = fd_total;
        push(4'd3, 4'd5);
        push(4'd2, 4'd7);
        push(4'd1, 4'd1);
        push(4'd4, 4'd4);
        pulse_start();
        wait_fd("basic_fd_timeout");
        check("basic_acc", acc - a0, 46);
        check("basic_valid_cnt", vcount - v0, 4);
        check("basic_fd_cnt", fd_total - f0, 1);

        // Starvation with bubbles
        a0 = acc; v0 = vcount; f0 = fd_total;
        push(4'd2, 4'd3);
        pulse_start();
        step();
        step();
        @(negedge clk);
        check("bubble_valid", out_valid, 0);
        check("bubble_data_a", Data_a, 0);
        step();
        push(4'd1, 4'd4);
        push(4'd5, 4'd5);
        push(4'd6, 4'd1);
        wait_fd("starve_fd_timeout");
        check("starve_acc", acc - a0, 41);
        check("starve_valid_cnt", vcount - v0, 4);
        check("starve_fd_cnt", fd_total - f0, 1);

        // Mid-frame reset with 3 pairs buffered
        push(4'd7, 4'd7);
        push(4'd8, 4'd8);
        push(4'd9, 4'd9);
        check("pre_rst_level", level, 3);
        pulse_start();
        step();
        rst_b = 1'b0;
        @(negedge clk);
        check("mid_rst_level", level, 0);
        check("mid_rst_data_b", Data_b, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        step();
        rst_b = 1'b1;
        step();

        // Full FIFO, rejected push, two frames across the pointer wrap
        for (int k = 0; k < 8; k++) push(4'(k + 1), 4'(k + 8));
        check("full_level", level, 8);
        check("full_in_ready", in_ready, 0);
        push(4'd15, 4'd15);
        check("full_reject_level", level, 8);
        v0 = vcount; f0 = fd_total;
        for (int i = 0; i < 16; i++) begin
            start    = (i == 0 || i == 6);
            in_valid = in_ready;
            in_a     = 4'(i);
            in_b     = 4'(15 - i);
            step();
        end
        start    = 1'b0;
        in_valid = 1'b0;
        step();
        check("wrap_fd_cnt", fd_total - f0, 2);
        check("wrap_valid_cnt", vcount - v0, 8);
        check("max_level", max_level, 8);
        rst_b = 1'b0;
        step();
        rst_b = 1'b1;
        step();

        // Push+pop at level 2, then push into an empty FIFO mid-frame
        push(4'd1, 4'd2);
        push(4'd3, 4'd4);
        pulse_start();
        push(4'd5, 4'd6);
        @(negedge clk);
        check("pushpop_level", level, 2);
        step();
        step();
        push(4'd7, 4'd8);
        @(negedge clk);
        check("no_bypass_valid", out_valid, 0);
        check("no_bypass_level", level, 1);
        @(negedge clk);
        check("late_pop_valid", out_valid, 1);
        check("late_pop_a", Data_a, 7);
        check("late_pop_b", Data_b, 8);
        wait_fd("late_fd_timeout");

        // start pulses during STREAM and DONE are ignored
        v0 = vcount; f0 = fd_total;
        for (int k = 0; k < 6; k++) push(4'(k + 2), 4'(k + 3));
        for (int i = 0; i < 12; i++) begin
            start = (i == 0 || i == 2 || i == 5);
            step();
        end
        start = 1'b0;
        step();
        check("ignore_fd_cnt", fd_total - f0, 1);
        check("ignore_valid_cnt", vcount - v0, 4);
        check("ignore_level", level, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
